// File: rtl/cmd_capture_fifo.sv
// cmd_capture_fifo
// -----------------------------------------------------------------------------
// Captures command words strobed in from the Pico data bus handshake and
// buffers them in a first-word-fall-through circular FIFO for the filter core.
//
// Parameters:
//   DATA_WIDTH      width of each captured word
//   DEPTH           number of entries (power of two, >= 2)
//
// Ports:
//   clk             system clock, rising edge
//   reset_n         asynchronous active-low reset (pointers, count, overflow)
//   data_in         word to capture
//   new_data_pulse  capture strobe, one word per high cycle
//   out_data        oldest stored word (valid while out_valid=1)
//   out_valid       FIFO not empty
//   out_ready       consumer accepts out_data this cycle
//   full / empty    occupancy flags derived from the registered count
//   count           number of stored words
//   overflow        sticky: a word was dropped because the FIFO was full
//   clear_overflow  synchronous clear of overflow (a same-cycle drop wins)
//   drop_count      (only with CMD_CAPTURE_DROP_CNT_EN) saturating count of
//                   dropped words, cleared together with overflow
//
// Optional feature macro: CMD_CAPTURE_DROP_CNT_EN
// -----------------------------------------------------------------------------
module cmd_capture_fifo #(
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    new_data_pulse,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   input  logic                    clear_overflow
`ifdef CMD_CAPTURE_DROP_CNT_EN
   ,
   output logic [7:0]              drop_count
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic                  overflow_r;
   logic                  full_s;
   logic                  empty_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  drop_s;

   // Pointer advance with explicit wrap from DEPTH-1 back to 0.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) begin
         return '0;
      end else begin
         return ptr + PTR_W'(1);
      end
   endfunction

   // Occupancy flags and push/pop/drop decisions; a pop frees the slot that a
   // push into a full FIFO needs, so that push is accepted.
   always_comb begin
      empty_s = (count_r == CNT_W'(0));
      full_s  = (count_r == CNT_W'(DEPTH));
      pop_s   = !empty_s && out_ready;
      push_s  = new_data_pulse && (!full_s || pop_s);
      drop_s  = new_data_pulse && full_s && !pop_s;
   end

   // Storage array: written on push only, deliberately not reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= data_in;
      end
   end

   // Read/write pointers and occupancy count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= next_ptr(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky overflow flag; a drop in the clearing cycle keeps it set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (clear_overflow) begin
         overflow_r <= 1'b0;
      end
   end

`ifdef CMD_CAPTURE_DROP_CNT_EN
   logic [7:0] drop_count_r;

   // Saturating drop counter; a drop in the clearing cycle restarts it at 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_count_r <= 8'd0;
      end else if (clear_overflow) begin
         drop_count_r <= drop_s ? 8'd1 : 8'd0;
      end else if (drop_s && (drop_count_r != 8'd255)) begin
         drop_count_r <= drop_count_r + 8'd1;
      end
   end

   assign drop_count = drop_count_r;
`endif

   assign out_data  = mem_r[rd_ptr_r];
   assign out_valid = !empty_s;
   assign empty     = empty_s;
   assign full      = full_s;
   assign count     = count_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_cmd_capture_fifo.sv
// Testbench for cmd_capture_fifo: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the FIFO behaviour.
module tb_cmd_capture_fifo;

   localparam int DW = 4;
   localparam int DP = 4;

   logic          clk;
   logic          reset_n;
   logic [DW-1:0] data_in;
   logic          new_data_pulse;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          full;
   logic          empty;
   logic [2:0]    count;
   logic          overflow;
   logic          clear_overflow;
`ifdef CMD_CAPTURE_DROP_CNT_EN
   logic [7:0]    drop_count;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DW-1:0] mq[$];
   logic          m_ovf;
   int            m_drop;

   cmd_capture_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .data_in(data_in),
      .new_data_pulse(new_data_pulse),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .full(full),
      .empty(empty),
      .count(count),
      .overflow(overflow),
      .clear_overflow(clear_overflow)
`ifdef CMD_CAPTURE_DROP_CNT_EN
      ,
      .drop_count(drop_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      mq.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
   endtask

   // Drive one cycle of inputs, advance the model, and return at the next negedge.
   task automatic drive(input logic p, input logic [DW-1:0] d, input logic r, input logic c);
      bit pop, push, drop;
      new_data_pulse = p;
      data_in        = d;
      out_ready      = r;
      clear_overflow = c;
      pop  = (mq.size() > 0) && r;
      push = p && ((mq.size() < DP) || pop);
      drop = p && (mq.size() == DP) && !pop;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(d);
      if (drop) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (c) m_drop = drop ? 1 : 0;
      else if (drop && m_drop < 255) m_drop++;
      @(posedge clk);
      @(negedge clk);
      new_data_pulse = 1'b0;
      out_ready      = 1'b0;
      clear_overflow = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      new_data_pulse = 1'b0; data_in = '0; out_ready = 1'b0; clear_overflow = 1'b0;
      model_reset();
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [DW-1:0] exp_w [3];
      exp_w[0] = 4'h3; exp_w[1] = 4'h7; exp_w[2] = 4'hA;
      for (int i = 0; i < 3; i++) drive(1'b1, exp_w[i], 1'b0, 1'b0);
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", count); end
      checks++; if (out_data !== 4'h3) begin errors++; $display("FAIL basic_head: got %0h expected 3", out_data); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin
            errors++; $display("FAIL basic_drain%0d: got v=%0b d=%0h expected v=1 d=%0h", i, out_valid, out_data, exp_w[i]);
         end
         drive(1'b0, 4'h0, 1'b1, 1'b0);
      end
      checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: got e=%0b v=%0b expected e=1 v=0", empty, out_valid); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DP; i++) drive(1'b1, 4'(i + 1), 1'b0, 1'b0);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %0b expected 1", full); end
      drive(1'b1, 4'hF, 1'b0, 1'b0);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", overflow); end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", count); end
      checks++; if (out_data !== 4'h1) begin errors++; $display("FAIL ovf_head: got %0h expected 1", out_data); end
`ifdef CMD_CAPTURE_DROP_CNT_EN
      checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL ovf_dropcnt: got %0d expected 1", drop_count); end
`endif
      drive(1'b0, 4'h0, 1'b0, 1'b1);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b expected 0", overflow); end
`ifdef CMD_CAPTURE_DROP_CNT_EN
      checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL ovf_dropcnt_clr: got %0d expected 0", drop_count); end
`endif
      // Drop in the clearing cycle: set wins
      drive(1'b1, 4'hE, 1'b0, 1'b1);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_setwins: got %0b expected 1", overflow); end
`ifdef CMD_CAPTURE_DROP_CNT_EN
      checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL ovf_dropcnt_setwins: got %0d expected 1", drop_count); end
`endif
      drive(1'b0, 4'h0, 1'b0, 1'b1);
   endtask

   task automatic test_full_push_pop();
      logic [DW-1:0] exp_d;
      drive(1'b1, 4'h9, 1'b1, 1'b0);
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL fpp_count: got %0d expected 4", count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %0b expected 0", overflow); end
      for (int i = 0; i < DP; i++) begin
         exp_d = mq[0];
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_d) begin
            errors++; $display("FAIL fpp_drain%0d: got v=%0b d=%0h expected v=1 d=%0h", i, out_valid, out_data, exp_d);
         end
         if (i == DP - 1) begin
            checks++; if (out_data !== 4'h9) begin errors++; $display("FAIL fpp_last: got %0h expected 9", out_data); end
         end
         drive(1'b0, 4'h0, 1'b1, 1'b0);
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fpp_empty: got %0b expected 1", empty); end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] d;
      // Continuous push with pop every cycle; single-word push while empty is not popped same edge
      for (int i = 0; i < 10; i++) begin
         d = 4'($urandom_range(15));
         drive(1'b1, d, 1'b1, 1'b0);
         checks++;
         if (out_valid !== 1'b1 || out_data !== d || count !== 3'd1) begin
            errors++; $display("FAIL wrap%0d: got v=%0b d=%0h c=%0d expected v=1 d=%0h c=1", i, out_valid, out_data, count, d);
         end
      end
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      checks++; if (empty !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL wrap_end: got e=%0b o=%0b expected e=1 o=0", empty, overflow); end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 4'h2, 1'b0, 1'b0);
      drive(1'b1, 4'h4, 1'b0, 1'b0);
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL arst_pre: got %0d expected 2", count); end
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL arst_now: got v=%0b c=%0d expected v=0 c=0", out_valid, count); end
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b1, 4'h5, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_data !== 4'h5) begin errors++; $display("FAIL arst_push: got v=%0b d=%0h expected v=1 d=5", out_valid, out_data); end
      drive(1'b0, 4'h0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [DW-1:0] exp_d;
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(99) < 60, 4'($urandom_range(15)), $urandom_range(99) < 45, $urandom_range(99) < 5);
         checks++;
         if (count !== 3'(mq.size()) || full !== (mq.size() == DP) || empty !== (mq.size() == 0) ||
             out_valid !== (mq.size() != 0) || overflow !== m_ovf) begin
            errors++; $display("FAIL rand_flags%0d: got c=%0d f=%0b e=%0b v=%0b o=%0b expected c=%0d o=%0b",
                               i, count, full, empty, out_valid, overflow, mq.size(), m_ovf);
         end
         if (mq.size() != 0) begin
            exp_d = mq[0];
            checks++; if (out_data !== exp_d) begin errors++; $display("FAIL rand_data%0d: got %0h expected %0h", i, out_data, exp_d); end
         end
`ifdef CMD_CAPTURE_DROP_CNT_EN
         checks++; if (drop_count !== 8'(m_drop)) begin errors++; $display("FAIL rand_dropcnt%0d: got %0d expected %0d", i, drop_count, m_drop); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_wrap();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
